itch_frame_reader: RTL and testbench

Consumer side of the ITCH byte FIFO. Pops bytes through the FIFO read port (`rd_en`/`dout`/`empty`) and strips the 2-byte big-endian length prefix of each ITCH message. It presents the payload as a framed valid/ready byte stream with start/end markers, message type and length to the speculative parser. Oversize and zero-length frames are discarded and flagged.

---
 rtl/itch_pkg.sv | 14 +
 rtl/byte_skid_buf.sv | 45 ++++
 rtl/itch_frame_reader.sv | 150 +++++++++++++++
 tb/tb_itch_frame_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// Shared constants and state encodings for the ITCH frame reader.
package itch_pkg;

   localparam int ITCH_LEN_WIDTH = 16;
   localparam int ITCH_MAX_LEN   = 64;

   typedef logic [1:0] itch_state_t;

   localparam itch_state_t LEN_HI  = 2'd0;
   localparam itch_state_t LEN_LO  = 2'd1;
   localparam itch_state_t PAYLOAD = 2'd2;
   localparam itch_state_t DROP    = 2'd3;

endpackage

// File: rtl/byte_skid_buf.sv
// Two-entry FIFO-ordered valid/ready buffer; exposes its occupancy so the
// producer can throttle upstream reads before the buffer can overflow.
module byte_skid_buf #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [0:1];
   logic             head;
   logic             push;
   logic             pop;

   assign out_valid = (count != 2'd0);
   assign out_data  = mem[head];
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && (count != 2'd2);

   // Storage, read pointer and occupancy; a write lands behind the current head.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
         head  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[head ^ count[0]] <= in_data;
         end
         if (pop) begin
            head <= ~head;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/itch_frame_reader.sv
// Pops bytes from the ITCH FIFO, strips the big-endian length prefix and
// presents each payload as a framed valid/ready byte stream.
module itch_frame_reader
   import itch_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = ITCH_LEN_WIDTH,
   parameter int MAX_LEN    = ITCH_MAX_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_sof,
   output logic                  m_eof,
   output logic [7:0]            msg_type,
   output logic [LEN_WIDTH-1:0]  msg_len,
   output logic                  err_len,
   output logic                  busy
);

   localparam logic [LEN_WIDTH-1:0] MAX_LEN_W = LEN_WIDTH'(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0] ONE_W     = LEN_WIDTH'(1);

   itch_state_t                      state;
   logic                             rd_pending;
   logic [LEN_WIDTH-DATA_WIDTH-1:0]  len_hi;
   logic [LEN_WIDTH-1:0]             len_word;
   logic [LEN_WIDTH-1:0]             cnt;
   logic [LEN_WIDTH-1:0]             frame_len;
   logic                             first;
   logic                             last_byte;
   logic                             pay_byte;
   logic                             sof_push;
   logic                             pop;
   logic [1:0]                       occ;
   logic [1:0]                       ahead;
   logic [2:0]                       load;
   logic [7:0]                       pend_type;
   logic [LEN_WIDTH-1:0]             pend_len;
   logic                             pend_valid;

   assign len_word  = {len_hi, fifo_dout};
   assign last_byte = (cnt == ONE_W);
   assign pay_byte  = rd_pending && (state == PAYLOAD);
   assign sof_push  = pay_byte && first;
   assign pop       = m_valid && m_ready;
   assign ahead     = occ - {1'b0, pop};

   // A byte leaving this cycle frees its slot in time for a read issued now,
   // which keeps payload throughput at one byte per cycle.
   assign load       = {1'b0, occ} - {2'b00, pop} + {2'b00, rd_pending};
   assign fifo_rd_en = !rst && !fifo_empty && (load < 3'd2);
   assign busy       = (state != LEN_HI) || (occ != 2'd0) || rd_pending;

   byte_skid_buf #(
      .WIDTH(DATA_WIDTH + 2)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .in_valid (pay_byte),
      .in_data  ({fifo_dout, first, last_byte}),
      .out_valid(m_valid),
      .out_ready(m_ready),
      .out_data ({m_data, m_sof, m_eof}),
      .count    (occ)
   );

   // Header decode and payload/drop byte counting, advanced on each arriving byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LEN_HI;
         rd_pending <= 1'b0;
         len_hi     <= '0;
         cnt        <= '0;
         frame_len  <= '0;
         first      <= 1'b0;
         err_len    <= 1'b0;
      end else begin
         rd_pending <= fifo_rd_en;
         err_len    <= 1'b0;
         if (rd_pending) begin
            case (state)
               LEN_HI: begin
                  len_hi <= fifo_dout[LEN_WIDTH-DATA_WIDTH-1:0];
                  state  <= LEN_LO;
               end
               LEN_LO: begin
                  frame_len <= len_word;
                  cnt       <= len_word;
                  first     <= 1'b1;
                  if (len_word == '0) begin
                     err_len <= 1'b1;
                     state   <= LEN_HI;
                  end else if (len_word > MAX_LEN_W) begin
                     err_len <= 1'b1;
                     state   <= DROP;
                  end else begin
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  cnt   <= cnt - ONE_W;
                  first <= 1'b0;
                  if (last_byte) state <= LEN_HI;
               end
               DROP: begin
                  cnt <= cnt - ONE_W;
                  if (last_byte) state <= LEN_HI;
               end
               default: state <= LEN_HI;
            endcase
         end
      end
   end

   // Message type/length follow the sof entry: if an older entry is still ahead
   // of it in the buffer, the new header waits in a pending slot until that
   // entry is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         msg_type   <= '0;
         msg_len    <= '0;
         pend_type  <= '0;
         pend_len   <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (pop && pend_valid) begin
            msg_type   <= pend_type;
            msg_len    <= pend_len;
            pend_valid <= 1'b0;
         end
         if (sof_push) begin
            if (ahead == 2'd0) begin
               msg_type <= fifo_dout[7:0];
               msg_len  <= frame_len;
            end else begin
               pend_type  <= fifo_dout[7:0];
               pend_len   <= frame_len;
               pend_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_itch_frame_reader.sv
// Bench for itch_frame_reader: behavioural FIFO feeding the reader, a
// scoreboard of expected beats, a table of frame vectors and hand-written
// sequences for back-to-back, stall and mid-frame reset cases.
module tb_itch_frame_reader;

   localparam int MAXL = 64;

   typedef struct packed {
      logic [7:0]  d;
      logic        sof;
      logic        eof;
      logic [7:0]  t;
      logic [15:0] l;
   } beat_t;

   typedef struct {
      logic [15:0] len;
      int          nbytes;
      logic [7:0]  seed;
      int          exp_err;
      int          exp_beats;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  fifo_dout = 8'h00;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_sof;
   logic        m_eof;
   logic [7:0]  msg_type;
   logic [15:0] msg_len;
   logic        err_len;
   logic        busy;

   logic [7:0]  fmem [0:1023];
   int          wp = 0;
   int          rp = 0;

   beat_t       exq [0:1023];
   int          ew = 0;
   int          er = 0;
   int          beat_cyc [0:1023];
   logic [7:0]  pl [0:127];
   vec_t        vt [0:4];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          beats = 0;
   int          rd_cnt = 0;
   int          err_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [10:0] prev_out = '0;

   always #5 clk = ~clk;

   itch_frame_reader #(
      .DATA_WIDTH(8),
      .LEN_WIDTH (16),
      .MAX_LEN   (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .fifo_dout (fifo_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_sof     (m_sof),
      .m_eof     (m_eof),
      .msg_type  (msg_type),
      .msg_len   (msg_len),
      .err_len   (err_len),
      .busy      (busy)
   );

   // Behavioural FIFO: data one cycle after the pop, cleared by the shared reset.
   assign fifo_empty = (rp == wp);

   always @(posedge clk) begin
      if (rst) begin
         rp <= wp;
      end else if (fifo_rd_en && (rp != wp)) begin
         fifo_dout <= fmem[rp];
         rp        <= rp + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sampled at the falling edge: values here are what the next rising edge sees.
   task automatic monitor();
      chk("rd_en_while_empty", {63'd0, fifo_rd_en && fifo_empty}, 64'd0);
      if (fifo_rd_en) rd_cnt++;
      if (err_len) err_cnt++;
      if (prev_stall) chk("stall_hold", {53'd0, m_valid, m_sof, m_eof, m_data}, {53'd0, prev_out});
      if (m_valid && m_ready) begin
         beat_cyc[beats] = cyc;
         beats++;
         if (er == ew) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h sof %0b eof %0b expected no beat", m_data, m_sof, m_eof);
         end else begin
            chk("beat", {30'd0, m_data, m_sof, m_eof, msg_type, msg_len}, {30'd0, exq[er]});
            er++;
         end
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_valid, m_sof, m_eof, m_data};
   endtask

   task automatic step(input logic rdy, input logic r);
      @(posedge clk);
      #1;
      cyc++;
      m_ready = rdy;
      rst     = r;
      @(negedge clk);
      if (r) begin
         er         = ew;
         prev_stall = 1'b0;
      end else begin
         monitor();
      end
   endtask

   task automatic load_frame(input logic [15:0] len, input int n);
      @(posedge clk);
      #1;
      cyc++;
      fmem[wp]     = len[15:8];
      fmem[wp + 1] = len[7:0];
      wp           = wp + 2;
      for (int i = 0; i < n; i++) begin
         fmem[wp] = pl[i];
         wp++;
      end
      if ((len != 16'd0) && (int'(len) <= MAXL)) begin
         for (int i = 0; i < int'(len); i++) begin
            exq[ew] = '{d: pl[i], sof: (i == 0), eof: (i == int'(len) - 1), t: pl[0], l: len};
            ew++;
         end
      end
      @(negedge clk);
      monitor();
   endtask

   // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0,1 repeating.
   task automatic run(input int mode, input int budget);
      logic idle;
      logic rdy;
      idle = 1'b0;
      for (int k = 0; k < budget && !idle; k++) begin
         rdy = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
         step(rdy, 1'b0);
         idle = (er == ew) && (rp == wp) && !busy && !fifo_rd_en;
      end
      if (!idle) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got pending %0d beats expected 0 within %0d cycles", ew - er, budget);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_rd_en"},    {63'd0, fifo_rd_en}, 64'd0);
      chk({name, "_m_valid"},  {63'd0, m_valid},    64'd0);
      chk({name, "_m_data"},   {56'd0, m_data},     64'd0);
      chk({name, "_m_sof"},    {63'd0, m_sof},      64'd0);
      chk({name, "_m_eof"},    {63'd0, m_eof},      64'd0);
      chk({name, "_msg_type"}, {56'd0, msg_type},   64'd0);
      chk({name, "_msg_len"},  {48'd0, msg_len},    64'd0);
      chk({name, "_err_len"},  {63'd0, err_len},    64'd0);
      chk({name, "_busy"},     {63'd0, busy},       64'd0);
   endtask

   initial begin
      int b0;
      int e0;
      int r0;

      vt[0] = '{16'd1,  1,  8'hC3, 0, 1};
      vt[1] = '{16'd64, 64, 8'h10, 0, 64};
      vt[2] = '{16'd65, 65, 8'h20, 1, 0};
      vt[3] = '{16'd0,  0,  8'h00, 1, 0};
      vt[4] = '{16'd2,  2,  8'h5A, 0, 2};

      rst     = 1'b1;
      m_ready = 1'b0;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk_all_zero("reset");

      // 00 03 41 11 22: three consecutive beats.
      b0 = beats;
      pl[0] = 8'h41; pl[1] = 8'h11; pl[2] = 8'h22;
      load_frame(16'd3, 3);
      run(0, 100);
      chk("t1_beats", 64'(beats - b0), 64'd3);
      chk("t1_consecutive", 64'(beat_cyc[b0 + 2] - beat_cyc[b0]), 64'd2);

      // Back-to-back 00 01 53 / 00 02 45 99: only the two header cycles between frames.
      b0 = beats;
      pl[0] = 8'h53;
      load_frame(16'd1, 1);
      pl[0] = 8'h45; pl[1] = 8'h99;
      load_frame(16'd2, 2);
      run(0, 100);
      chk("t2_beats", 64'(beats - b0), 64'd3);
      chk("t2_frame_gap", 64'(beat_cyc[b0 + 1] - beat_cyc[b0]), 64'd3);
      chk("t2_intra_gap", 64'(beat_cyc[b0 + 2] - beat_cyc[b0 + 1]), 64'd1);

      // Zero-length header then 00 01 7A.
      b0 = beats; e0 = err_cnt;
      load_frame(16'd0, 0);
      pl[0] = 8'h7A;
      load_frame(16'd1, 1);
      run(0, 100);
      chk("t3_err", 64'(err_cnt - e0), 64'd1);
      chk("t3_beats", 64'(beats - b0), 64'd1);

      // Oversize 00 50 with 80 bytes dropped, then 00 01 33.
      b0 = beats; e0 = err_cnt;
      for (int i = 0; i < 80; i++) pl[i] = 8'(i + 1);
      load_frame(16'h0050, 80);
      pl[0] = 8'h33;
      load_frame(16'd1, 1);
      run(0, 400);
      chk("t4_err", 64'(err_cnt - e0), 64'd1);
      chk("t4_beats", 64'(beats - b0), 64'd1);

      // 10-byte frame under m_ready 1,0,0,1,...: exactly 12 pops.
      b0 = beats; r0 = rd_cnt;
      for (int i = 0; i < 10; i++) pl[i] = 8'hB0 + 8'(i);
      load_frame(16'd10, 10);
      run(1, 200);
      chk("t5_beats", 64'(beats - b0), 64'd10);
      chk("t5_pops", 64'(rd_cnt - r0), 64'd12);

      // Table of frame-length boundaries.
      for (int v = 0; v < 5; v++) begin
         b0 = beats; e0 = err_cnt;
         for (int i = 0; i < vt[v].nbytes; i++) pl[i] = vt[v].seed ^ 8'(i * 37);
         load_frame(vt[v].len, vt[v].nbytes);
         run(0, 400);
         chk($sformatf("vec%0d_err", v), 64'(err_cnt - e0), 64'(vt[v].exp_err));
         chk($sformatf("vec%0d_beats", v), 64'(beats - b0), 64'(vt[v].exp_beats));
      end

      // Reset after two beats of a 5-byte frame, then 00 01 42.
      b0 = beats;
      for (int i = 0; i < 5; i++) pl[i] = 8'hA0 + 8'(i);
      load_frame(16'd5, 5);
      for (int k = 0; k < 50 && beats < b0 + 2; k++) step(1'b1, 1'b0);
      chk("t6_two_beats", 64'(beats - b0), 64'd2);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      chk_all_zero("midreset");
      b0 = beats;
      pl[0] = 8'h42;
      load_frame(16'd1, 1);
      run(0, 100);
      chk("t6_after_beats", 64'(beats - b0), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
